ram_arbiter: RTL and testbench

//  Single-port SRAM controller and arbiter shared by IF (instruction fetch) and MEM (data access).

---
 rtl/ram_arbiter_pkg.sv | 30 +++
 rtl/ram_arbiter.sv | 149 ++++++++++++++
 tb/tb_ram_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_pkg.sv
// Shared encodings for the IF/MEM single-port SRAM arbiter.
package ram_arbiter_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_READ,
    ARB_WR_SETUP,
    ARB_WR_PULSE,
    ARB_WR_HOLD,
    ARB_DONE
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_MEM
  } owner_e;

  localparam logic [1:0] MEMRW_IDLE  = 2'b00;
  localparam logic [1:0] MEMRW_READ  = 2'b01;
  localparam logic [1:0] MEMRW_WRITE = 2'b10;

  localparam logic STALL_YES = 1'b1;
  localparam logic STALL_NO  = 1'b0;

  // 2'b11 is treated as idle, so only the two defined opcodes count as a request.
  function automatic logic is_mem_req(input logic [1:0] rw);
    return (rw == MEMRW_READ) || (rw == MEMRW_WRITE);
  endfunction

endpackage

// File: rtl/ram_arbiter.sv
// SRAM controller/arbiter shared by instruction fetch and data access; MEM wins over IF.
// Stalls the pipeline until every pending request has been served exactly once.
//
// state        | meaning
// ARB_IDLE     | strobes high, grant made at end of cycle (MEM first)
// ARB_READ     | ce_n/oe_n low for WAIT_CYC+1 cycles, last cycle samples ram_data
// ARB_WR_SETUP | ce_n low, data driven, we_n still high
// ARB_WR_PULSE | we_n low for WAIT_CYC+1 cycles
// ARB_WR_HOLD  | we_n high, address/data still driven
// ARB_DONE     | strobes high, bus released, owner reported served
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic [1:0]        mem_memrw,
  input  logic [ADDR_W-1:0] mem_memaddr,
  input  logic [DATA_W-1:0] mem_memdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_req,
  output logic [ADDR_W-1:0] ram_addr,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n
);

  localparam int CNT_W = $clog2(WAIT_CYC + 2);

  arb_state_e        state;
  owner_e            owner;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] wdata_q;
  logic              drive_q;
  logic              mem_done_q;
  logic              if_done_q;
  logic              mem_req;
  logic              mem_ok;
  logic              if_ok;

  assign mem_req = is_mem_req(mem_memrw);
  assign mem_ok  = mem_done_q | ((state == ARB_DONE) && (owner == OWN_MEM));
  assign if_ok   = if_done_q  | ((state == ARB_DONE) && (owner == OWN_IF));

  // Handshake outputs are gated so nothing reports busy/served while in reset.
  assign stall_req = rst & ((mem_req & ~mem_ok) | (if_req & ~if_ok));
  assign mem_ready = rst & mem_ok;
  assign if_ready  = rst & if_ok;

  assign ram_data = drive_q ? wdata_q : {DATA_W{1'bz}};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB_IDLE;
      owner      <= OWN_IF;
      cnt        <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      mem_done_q <= 1'b0;
      if_done_q  <= 1'b0;
      ram_addr   <= '0;
      ram_ce_n   <= 1'b1;
      ram_oe_n   <= 1'b1;
      ram_we_n   <= 1'b1;
      mem_rdata  <= '0;
      if_rdata   <= '0;
    end else begin
      // Done flags remember who was served until the pipeline advances.
      if (stall_req == STALL_NO) begin
        mem_done_q <= 1'b0;
        if_done_q  <= 1'b0;
      end else if (state == ARB_DONE) begin
        if (owner == OWN_MEM) mem_done_q <= 1'b1;
        else                  if_done_q  <= 1'b1;
      end

      case (state)
        ARB_IDLE: begin
          if (mem_req && !mem_done_q) begin
            owner    <= OWN_MEM;
            ram_addr <= mem_memaddr;
            wdata_q  <= mem_memdata;
            ram_ce_n <= 1'b0;
            if (mem_memrw == MEMRW_WRITE) begin
              drive_q <= 1'b1;
              state   <= ARB_WR_SETUP;
            end else begin
              ram_oe_n <= 1'b0;
              cnt      <= CNT_W'(WAIT_CYC);
              state    <= ARB_READ;
            end
          end else if (if_req && !if_done_q) begin
            owner    <= OWN_IF;
            ram_addr <= if_addr;
            ram_ce_n <= 1'b0;
            ram_oe_n <= 1'b0;
            cnt      <= CNT_W'(WAIT_CYC);
            state    <= ARB_READ;
          end
        end
        ARB_READ: begin
          if (cnt == '0) begin
            if (owner == OWN_MEM) mem_rdata <= ram_data;
            else                  if_rdata  <= ram_data;
            ram_ce_n <= 1'b1;
            ram_oe_n <= 1'b1;
            state    <= ARB_DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARB_WR_SETUP: begin
          ram_we_n <= 1'b0;
          cnt      <= CNT_W'(WAIT_CYC);
          state    <= ARB_WR_PULSE;
        end
        ARB_WR_PULSE: begin
          if (cnt == '0) begin
            ram_we_n <= 1'b1;
            state    <= ARB_WR_HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ARB_WR_HOLD: begin
          ram_ce_n <= 1'b1;
          drive_q  <= 1'b0;
          state    <= ARB_DONE;
        end
        ARB_DONE: begin
          state <= ARB_IDLE;
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: async SRAM model plus a transaction-level reference of cost and data.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic [15:0] if_rdata;
  logic        if_ready;
  logic [1:0]  mem_memrw = 2'b00;
  logic [15:0] mem_memaddr = '0;
  logic [15:0] mem_memdata = '0;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        stall_req;
  logic [15:0] ram_addr;
  wire  [15:0] ram_data;
  logic        ram_ce_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] sram [16];
  logic [15:0] ref_mem [16];
  logic        sram_init = 1'b0;
  int          starts = 0;
  logic        prev_ce_n = 1'b1;
  logic        prev_wr = 1'b0;

  ram_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYC(1)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_memrw(mem_memrw), .mem_memaddr(mem_memaddr), .mem_memdata(mem_memdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_req(stall_req),
    .ram_addr(ram_addr), .ram_data(ram_data),
    .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_word(input int i);
    logic [31:0] w;
    w = (i * 32'h1111) ^ 32'h0f0f;
    return (i == 5) ? 16'h1234 : w[15:0];
  endfunction

  assign ram_data = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr[3:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!sram_init) begin
      for (int i = 0; i < 16; i++) sram[i] <= init_word(i);
      sram_init <= 1'b1;
    end else if (!ram_ce_n && !ram_we_n) begin
      sram[ram_addr[3:0]] <= ram_data;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Bus protocol monitor: no read may directly follow a write cycle, OE and WE never both low.
  always @(negedge clk) begin
    if (prev_ce_n && !ram_ce_n) starts++;
    if (!ram_ce_n && !ram_oe_n) begin
      check_val("turnaround", {31'b0, prev_wr}, 32'd0);
      check_val("oe_we_overlap", {31'b0, !ram_we_n}, 32'd0);
    end
    prev_wr   = !ram_ce_n && ram_oe_n;
    prev_ce_n = ram_ce_n;
  end

  // One pipeline step: inputs held until stall_req drops; cost and results from the reference.
  task automatic do_step(input logic [1:0] rw, input logic [15:0] maddr, input logic [15:0] mdata,
                         input logic ireq, input logic [15:0] iaddr);
    int cycles;
    int first_m;
    int s0;
    int exp_cycles;
    int m_cost;
    logic mreq;
    logic [15:0] exp_m;
    logic [15:0] exp_i;
    mreq   = (rw == 2'b01) || (rw == 2'b10);
    m_cost = (rw == 2'b01) ? 4 : (rw == 2'b10) ? 6 : 0;
    exp_cycles = m_cost + (ireq ? 4 : 0);
    if (exp_cycles == 0) exp_cycles = 1;
    if (rw == 2'b10) ref_mem[maddr[3:0]] = mdata;
    exp_m = ref_mem[maddr[3:0]];
    exp_i = ref_mem[iaddr[3:0]];

    mem_memrw = rw; mem_memaddr = maddr; mem_memdata = mdata;
    if_req = ireq; if_addr = iaddr;
    s0 = starts;
    cycles = 0;
    first_m = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (mem_ready && first_m == 0) first_m = cycles;
    end while (stall_req && cycles < 40);

    check_val("step_cycles", cycles, exp_cycles);
    check_val("accesses", starts - s0, int'(mreq) + int'(ireq));
    check_val("mem_ready", {31'b0, mem_ready}, {31'b0, mreq});
    check_val("if_ready", {31'b0, if_ready}, {31'b0, ireq});
    if (mreq) check_val("mem_ready_cycle", first_m, m_cost);
    if (rw == 2'b01) check_val("mem_rdata", mem_rdata, exp_m);
    if (rw == 2'b10) check_val("sram_write", sram[maddr[3:0]], mdata);
    if (ireq) check_val("if_rdata", if_rdata, exp_i);
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);

    // Requests pending during reset must not raise stall or ready.
    if_req = 1'b1; mem_memrw = 2'b01;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_stall", {31'b0, stall_req}, 32'd0);
    check_val("rst_if_ready", {31'b0, if_ready}, 32'd0);
    check_val("rst_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    check_val("rst_addr", ram_addr, 32'd0);
    check_val("rst_rdata", {mem_rdata, if_rdata}, 32'd0);
    if_req = 1'b0; mem_memrw = 2'b00;
    rst = 1'b1;
    @(posedge clk);
    #1;

    do_step(2'b10, 16'd2, 16'h0002, 1'b0, 16'd0);
    do_step(2'b01, 16'd2, 16'h0000, 1'b1, 16'd5);
    for (int a = 0; a < 4; a++) do_step(2'b00, 16'd0, 16'd0, 1'b1, 16'(a));
    do_step(2'b10, 16'd7, 16'hbeef, 1'b0, 16'd0);
    do_step(2'b01, 16'd7, 16'h0000, 1'b0, 16'd0);
    do_step(2'b10, 16'd3, 16'h7777, 1'b1, 16'd3);

    mem_memrw = 2'b11; if_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_val("rw11_stall", {31'b0, stall_req}, 32'd0);
      check_val("rw11_ce_n", {31'b0, ram_ce_n}, 32'd1);
    end
    @(posedge clk);
    #1;

    for (int n = 0; n < 60; n++)
      do_step(2'($urandom_range(0, 3)), 16'($urandom_range(0, 7)), 16'($urandom),
              1'($urandom_range(0, 1)), 16'($urandom_range(0, 7)));

    // Reset in the middle of a write pulse releases the strobes immediately.
    mem_memrw = 2'b10; mem_memaddr = 16'd15; mem_memdata = 16'hdead; if_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("pulse_we_n", {31'b0, ram_we_n}, 32'd0);
    rst = 1'b0;
    #1;
    check_val("abort_strobes", {29'b0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
    check_val("abort_stall", {31'b0, stall_req}, 32'd0);
    check_val("abort_ready", {31'b0, mem_ready}, 32'd0);
    mem_memrw = 2'b00;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    do_step(2'b01, 16'd2, 16'h0000, 1'b1, 16'd6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
